// File: rtl/obi_pkg.sv
// ============================================================================
//  Module   : obi_pkg
//  Brief    : Shared types, constants and helpers for the OBI memory responder
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_pkg;

  // Byte-enable width for the fixed 32-bit data bus
  localparam int unsigned OBI_BE_WIDTH = 4;

  // One response slot travelling down the read-latency pipeline
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  // Word index of a byte address: drop the two byte-offset bits and keep
  // idx_w bits above them. The address is passed zero-extended to 64 bits so
  // any ADDR_WIDTH up to 64 can share this helper.
  function automatic logic [31:0] obi_word_idx(input logic [63:0] addr,
                                               input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((addr >> 2) & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/obi_resp_pipe.sv
// ============================================================================
//  Module   : obi_resp_pipe
//  Brief    : Fixed-depth response shift register with asynchronous clear.
//             Stage 0 is loaded on the grant edge; the last stage drives the
//             registered response outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_resp_pipe
  import obi_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  obi_resp_t resp_i,
  output obi_resp_t resp_o
);

  obi_resp_t stage_q [LATENCY];
  obi_resp_t stage_d [LATENCY];

  // Shift: new response enters stage 0, every other stage takes its predecessor
  always_comb begin
    stage_d[0] = resp_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops every in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/obi_mem_responder.sv
// ============================================================================
//  Module   : obi_mem_responder
//  Brief    : Memory-side responder for the core request interface. Grants
//             requests (with optional stall back-pressure), commits byte-
//             enabled writes into a word RAM, returns one in-order response
//             per grant after a fixed latency, and counts granted requests.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_mem_responder
  import obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [OBI_BE_WIDTH-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    stall_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [31:0]             req_count_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic             commit;
  logic             out_of_range;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      req_count_q;
  logic [31:0]      req_count_d;
  obi_resp_t        resp_in;
  obi_resp_t        resp_out;

  // Grant is purely combinational and stays live during reset; only the
  // side effects (RAM write, counting, response) are suppressed there.
  assign gnt_o  = req_i & ~stall_i;
  assign commit = gnt_o & rst_n;

  // Address decode: any bit above the word-index field means out of range
  assign word_idx     = IDX_W'(obi_word_idx(64'(addr_i), IDX_W));
  assign out_of_range = (addr_i >> (IDX_W + 2)) != '0;

  // Byte-lane RAM write on the grant edge; contents are never reset
  always_ff @(posedge clk) begin
    if (commit && we_i && !out_of_range) begin
      for (int i = 0; i < int'(OBI_BE_WIDTH); i++) begin
        if (be_i[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Build the response entering stage 0; the RAM read sampled here is the
  // first latency cycle
  always_comb begin
    resp_in = '0;
    if (gnt_o) begin
      resp_in.valid = 1'b1;
      if (out_of_range) begin
        resp_in.err = 1'b1;
      end else if (!we_i) begin
        resp_in.rdata = mem_q[word_idx];
      end
    end
  end

  obi_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );

  assign rvalid_o = resp_out.valid;
  assign rdata_o  = resp_out.rdata;
  assign err_o    = resp_out.err;

  // Granted-request counter, wraps naturally at 2^32
  always_comb begin
    req_count_d = req_count_q + 32'(gnt_o);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_count_q <= '0;
    end else begin
      req_count_q <= req_count_d;
    end
  end

  assign req_count_o = req_count_q;

endmodule

`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
// ============================================================================
//  Module   : tb_obi_mem_responder
//  Brief    : Randomised + directed bench for obi_mem_responder with a
//             scheduled-response reference model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_mem_responder;

  localparam int unsigned LAT   = 3;
  localparam int unsigned WORDS = 1024;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] req_count_o;

  always #5 clk = ~clk;

  obi_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_WORDS  (WORDS),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .gnt_o       (gnt_o),
    .we_i        (we),
    .be_i        (be),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .stall_i     (stall),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .req_count_o (req_count_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  logic [31:0] ref_mem [WORDS];
  logic [31:0] ref_count = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: every accepted request schedules one response for the
  // cycle after edge (grant_edge + LAT - 1)
  always @(posedge clk) begin
    cyc++;
    if (rst_n && req && !stall) begin
      m_e.due   = cyc + int'(LAT) - 1;
      m_e.rdata = 32'h0;
      m_e.err   = 1'b0;
      if (addr >= 32'(WORDS * 4)) begin
        m_e.err = 1'b1;
      end else if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[addr / 4][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        m_e.rdata = ref_mem[addr / 4];
      end
      exp_q.push_back(m_e);
      ref_count = ref_count + 32'd1;
    end
  end

  // Output checker, sampled shortly after each rising edge
  always @(posedge clk) begin
    #3;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("rvalid", {31'b0, rvalid_o}, 32'd1);
      chk("rdata", rdata_o, exp_q[0].rdata);
      chk("err", {31'b0, err_o}, {31'b0, exp_q[0].err});
      void'(exp_q.pop_front());
    end else begin
      chk("rvalid_idle", {31'b0, rvalid_o}, 32'd0);
    end
    chk("req_count", req_count_o, ref_count);
    if (rvalid_o) begin
      last_rdata = rdata_o;
      last_err   = err_o;
    end
  end

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, input logic s);
    @(negedge clk);
    req = r; we = w; be = b; addr = a; wdata = d; stall = s;
    #1 chk("gnt", {31'b0, gnt_o}, {31'b0, r & ~s});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  logic [31:0] ra;

  initial begin
    // Reset phase: grants still visible on gnt_o but have no effect
    drive(1'b1, 1'b1, 4'hF, 32'h50, 32'h12345678, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h50, 32'h0, 1'b1);
    idle(1);
    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_count", req_count_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Initialise the words used by later reads
    for (int i = 0; i <= 16; i++) drive(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);
    idle(LAT + 1);

    // Write then read back
    drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    idle(LAT + 1);
    chk("deadbeef", last_rdata, 32'hDEADBEEF);
    chk("deadbeef_err", {31'b0, last_err}, 32'd0);

    // Partial byte-enable merge, then an all-zero byte-enable write
    drive(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0);
    drive(1'b1, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    idle(LAT + 1);
    chk("be_merge", last_rdata, 32'h11BB33DD);
    drive(1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h22, 32'h0, 1'b0);
    idle(LAT + 1);
    chk("be_zero", last_rdata, 32'h11BB33DD);

    // Out-of-range access, then a clean read of word 0
    drive(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, 1'b0);
    idle(LAT + 1);
    chk("oor_err", {31'b0, last_err}, 32'd1);
    chk("oor_rdata", last_rdata, 32'd0);
    drive(1'b1, 1'b1, 4'hF, 32'h8000_1000, 32'h5A5A5A5A, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    idle(LAT + 1);

    // Stall back-pressure for 5 cycles, then release
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
    idle(LAT + 1);

    // Mid-flight reset: write persists, in-flight reads are dropped
    drive(1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 1'b0;
    exp_q.delete();
    ref_count = 32'h0;
    idle(LAT + 1);
    chk("rst_mid_count", req_count_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Eight back-to-back reads
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b0);
    idle(LAT + 1);
    chk("count8", req_count_o, 32'd8);
    drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    idle(LAT + 1);
    chk("persist", last_rdata, 32'hCAFEF00D);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 8 == 0) ra = $urandom | 32'h1000;
      else                   ra = 32'(($urandom % 17) * 4 + ($urandom % 4));
      drive(($urandom % 4) != 0, ($urandom % 2) == 1, 4'($urandom), ra, $urandom,
            ($urandom % 5) == 0);
    end
    idle(LAT + 2);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/obi_mem_responder.md
# obi_mem_responder

Memory-side responder for the core's instruction/data request interface (req/gnt/rvalid handshake with byte enables). It backs either port of the core wrapper in simulation and FPGA builds with a word-addressed RAM, fixed pipelined read latency, and optional grant back-pressure. It grants requests, commits writes, and returns exactly one in-order response per granted request after a configurable latency. It also maintains a granted-request counter used to cross-check the core's `mem_req_count` trace output.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width. Fixed at 32; `be_i` is 4 bits.
- `MEM_WORDS`, 1024, RAM depth in 32-bit words. Must be a power of two.
- `LATENCY`, 2, cycles from grant edge to `rvalid_o` (≥1).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  grant; a request is accepted on an edge where `req_i & gnt_o`.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables for writes; ignored for reads.
- `addr_i`  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- `wdata_i`  in  32  write data.
- `stall_i`  in  1  back-pressure injection; forces `gnt_o` low.
- `rvalid_o`  out  1  response valid, one cycle per granted request.
- `rdata_o`  out  32  read data; 0 for writes and errors.
- `err_o`  out  1  response error, qualified by `rvalid_o`.
- `req_count_o`  out  32  total granted requests since reset.

## Operation
- `gnt_o = req_i & ~stall_i`, combinational. No outstanding limit is needed, because the fixed-latency pipeline always drains.
- Word index = `addr_i[2 +: log2(MEM_WORDS)]`. A request is out of range when any `addr_i` bit above the index field is set.
- Granted write, in range: each byte lane i with `be_i[i]=1` is written on the grant edge. The response has `rdata_o=0`, `err_o=0`.
- Granted read, in range: the word is sampled on the grant edge, so a write granted on an earlier edge is visible. The response carries the word and `err_o=0`.
- Out-of-range request: no RAM update. The response has `rdata_o=0`, `err_o=1`.
- Responses are in grant order. Back-to-back grants give back-to-back `rvalid_o`.
- `req_count_o` increments by 1 per grant and wraps 0xFFFF_FFFF→0.
- `be_i=0000` on a write is legal. No byte changes and the response is normal.

## Timing
- A grant on edge T makes `rvalid_o` high for the cycle following edge T+LATENCY-1. With LATENCY=1, the response appears in the cycle directly after the grant.
- `rvalid_o`, `rdata_o` and `err_o` are registered (last pipeline stage). No combinational path from inputs to them.
- Reset values: `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `req_count_o=0`. `gnt_o` follows `req_i & ~stall_i` even in reset, but grants during reset are not counted or committed. RAM contents are not reset.
- Reset asserted mid-operation clears every pipeline stage. In-flight responses are dropped and never emitted. Writes already granted remain in RAM.
- `stall_i` may toggle at any cycle. Responses already in flight still emerge at their scheduled cycle.
- Simultaneous grant and response in the same cycle is normal pipelined operation.

## Structure
- Shared package `obi_pkg` holds:
  - `obi_resp_t` struct {valid, rdata[31:0], err};
  - constant `OBI_BE_WIDTH=4`;
  - function `obi_word_idx`.
- Sub-module `obi_resp_pipe`: LATENCY-deep shift register of `obi_resp_t` with async clear. The top level contains the RAM, decode, grant and counter.
- RAM is a behavioural array with per-byte write, so it infers block RAM. Read sampling into pipeline stage 0 counts toward LATENCY.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010 with be=1111, then read 0x10 → read response rdata=0xDEADBEEF, err=0, LATENCY cycles after its grant.
- Write 0x11223344 to 0x20 (be=1111), then write 0xAABBCCDD to 0x20 with be=0101, then read 0x20 → 0x11BB33DD.
- Granted read at 0x0000_1000 with MEM_WORDS=1024 → err=1, rdata=0. A subsequent read of 0x0 shows no corruption.
- 8 back-to-back reads of 0x0,0x4,…,0x1C with LATENCY=3 → 8 consecutive rvalid cycles starting 3 cycles after the first grant, in order. `req_count_o=8`.
- `stall_i` high for 5 cycles while `req_i=1` → `gnt_o=0` and no rvalid for new requests. After release, the grant occurs and the response follows LATENCY later.
- Assert `rst_n=0` one cycle after 2 reads are granted (LATENCY=3) → no rvalid emitted, `req_count_o=0`. A write granted before reset persists on readback.
